// File: rtl/toeplitz_pkg.sv
// ------------------------------------------------------------------
// toeplitz_pkg: shared sizes, state encoding and error-bit indices
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package toeplitz_pkg;

  localparam int ROW_W   = 3072;
  localparam int WORD_W  = 32;
  localparam int N_REQ   = 128;
  localparam int N_WORDS = ROW_W / WORD_W;

  localparam int ERR_UFLOW = 0;
  localparam int ERR_PROTO = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  function automatic logic [ROW_W-1:0] rotl1(input logic [ROW_W-1:0] v);
    return {v[ROW_W-2:0], v[ROW_W-1]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/toeplitz_feeder_fifo.sv
// ------------------------------------------------------------------
// coeff_fifo: synchronous FIFO with pointer-wrap full/empty detection
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module coeff_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_pop;
  logic             do_push;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/toeplitz_feeder.sv
// ------------------------------------------------------------------
// toeplitz_feeder: seed loader, coefficient responder and result drain
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module toeplitz_feeder
  import toeplitz_pkg::*;
#(
  parameter int FIFO_D = 4
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              seed_valid,
  input  logic [WORD_W-1:0] seed_data,
  output logic              seed_ready,
  input  logic              cf_valid,
  input  logic [WORD_W-1:0] cf_data,
  output logic              cf_ready,
  input  logic              read_en,
  output logic [WORD_W-1:0] coeff,
  output logic [ROW_W-1:0]  shift_row,
  input  logic              write_en,
  input  logic [ROW_W-1:0]  final_result,
  output logic              res_valid,
  output logic [WORD_W-1:0] res_data,
  input  logic              res_ready,
  output logic              busy,
  output logic [1:0]        err
);

  localparam logic [5:0] ROT_N     = 6'(WORD_W);
  localparam logic [6:0] LAST_WORD = 7'(N_WORDS - 1);
  localparam logic [7:0] REQ_MAX   = 8'(N_REQ);

  state_e              state_q, state_d;
  logic [6:0]          word_cnt_q;
  logic [7:0]          req_cnt_q;
  logic [5:0]          rot_cnt_q;
  logic                start_q;
  logic                read_en_q;
  logic                seed_ready_q;
  logic                res_valid_q;
  logic [WORD_W-1:0]   coeff_q;
  logic [ROW_W-1:0]    shift_row_q;
  logic [ROW_W-1:0]    out_buf_q;
  logic [1:0]          err_q;

  logic                seed_hs, res_hs, last_word, rd_rise, rot_busy;
  logic                req_ok, req_bad, fifo_full, fifo_empty;
  logic [WORD_W-1:0]   fifo_rdata;

  coeff_fifo #(.DEPTH(FIFO_D), .WIDTH(WORD_W)) u_fifo (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .push_i  (cf_valid),
    .wdata_i (cf_data),
    .pop_i   (req_ok),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (seed_hs)              state_d = LOAD;
      LOAD:    if (seed_hs && last_word) state_d = RUN;
      RUN:     if (write_en)             state_d = DRAIN;
      DRAIN:   if (res_hs && last_word)  state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    last_word = (word_cnt_q == LAST_WORD);
    seed_hs   = seed_valid && seed_ready_q && (state_q == IDLE || state_q == LOAD);
    res_hs    = res_valid_q && res_ready && (state_q == DRAIN);
    rd_rise   = read_en && !read_en_q;
    // The final rotation edge may coincide with acceptance of the next request.
    rot_busy  = start_q || (rot_cnt_q > 6'd1);
    req_ok    = (state_q == RUN) && rd_rise && !rot_busy && (req_cnt_q != REQ_MAX);
    req_bad   = rd_rise && (((state_q == RUN) && !req_ok) || (state_q == DRAIN));
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q   <= '0;
      req_cnt_q    <= '0;
      rot_cnt_q    <= '0;
      start_q      <= 1'b0;
      read_en_q    <= 1'b0;
      seed_ready_q <= 1'b1;
      res_valid_q  <= 1'b0;
      coeff_q      <= '0;
      shift_row_q  <= '0;
      out_buf_q    <= '0;
      err_q        <= '0;
    end else begin
      read_en_q <= read_en;

      if (seed_hs) begin
        shift_row_q[int'(word_cnt_q)*WORD_W +: WORD_W] <= seed_data;
        word_cnt_q <= last_word ? 7'd0 : word_cnt_q + 7'd1;
        if (last_word) begin
          seed_ready_q <= 1'b0;
          req_cnt_q    <= '0;
        end
      end

      if (start_q) begin
        start_q   <= 1'b0;
        rot_cnt_q <= ROT_N;
      end else if (rot_cnt_q != 6'd0) begin
        shift_row_q <= rotl1(shift_row_q);
        rot_cnt_q   <= rot_cnt_q - 6'd1;
      end

      if (req_ok) begin
        start_q   <= 1'b1;
        req_cnt_q <= req_cnt_q + 8'd1;
        coeff_q   <= fifo_empty ? '0 : fifo_rdata;
        if (fifo_empty) err_q[ERR_UFLOW] <= 1'b1;
      end
      if (req_bad) err_q[ERR_PROTO] <= 1'b1;

      if (state_q == RUN && write_en) begin
        out_buf_q   <= final_result;
        res_valid_q <= 1'b1;
        word_cnt_q  <= '0;
      end

      if (res_hs) begin
        out_buf_q <= out_buf_q >> WORD_W;
        if (last_word) begin
          res_valid_q  <= 1'b0;
          shift_row_q  <= '0;
          word_cnt_q   <= '0;
          seed_ready_q <= 1'b1;
          start_q      <= 1'b0;
          rot_cnt_q    <= '0;
        end else begin
          word_cnt_q <= word_cnt_q + 7'd1;
        end
      end
    end
  end

  assign seed_ready = seed_ready_q;
  assign cf_ready   = !fifo_full;
  assign coeff      = coeff_q;
  assign shift_row  = shift_row_q;
  assign res_valid  = res_valid_q;
  assign res_data   = out_buf_q[WORD_W-1:0];
  assign err        = err_q;

endmodule

`default_nettype wire

// File: doc/toeplitz_feeder.md
# toeplitz_feeder

Responder for the Toeplitz row accumulator (`sum_row`). It loads a 3072-bit Toeplitz seed from a 32-bit word stream. It answers each `read_en` coefficient request with one buffered 32-bit coefficient word. It rotates the presented `shift_row` one bit per consumed coefficient bit. On `write_en` it captures `final_result` and streams it out as 32-bit words. It sits between the host/DMA streams and the accumulator, closing both ends of the accumulator's interface.

## Interface
- `ROW_W`, 3072, width of `shift_row` and `final_result`.
- `WORD_W`, 32, word width of the coefficient, seed and result streams.
- `N_REQ`, 128, coefficient requests per hash.
- `FIFO_D`, 4, coefficient FIFO depth (power of two).
- `clk_in`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `seed_valid` / `seed_data`  in  1 / WORD_W  seed word stream.
- `seed_ready`  out  1  seed word accepted when valid && ready.
- `cf_valid` / `cf_data`  in  1 / WORD_W  coefficient word stream into the FIFO.
- `cf_ready`  out  1  FIFO not full.
- `read_en`  in  1  coefficient request from the accumulator.
- `coeff`  out  WORD_W  coefficient word presented to the accumulator.
- `shift_row`  out  ROW_W  current Toeplitz row.
- `write_en`  in  1  accumulator result strobe.
- `final_result`  in  ROW_W  accumulator result.
- `res_valid` / `res_data`  out  1 / WORD_W  result word stream.
- `res_ready`  in  1  downstream accept.
- `busy`  out  1  state != IDLE.
- `err`  out  2  sticky flags: [0] FIFO underflow, [1] protocol error.

## Operation
- **Reset** (async, `rst_n`=0): state IDLE. `coeff`, `shift_row`, `res_data`, `err` and all counters are 0. `seed_ready`=1, `cf_ready`=1, `res_valid`=0, `busy`=0. FIFO is emptied.
- **IDLE.** `seed_ready`=1. The first accepted seed word loads `shift_row[31:0]` and moves the block to LOAD.
- **LOAD.** Word k loads `shift_row[32k+31:32k]`. After word 95 is accepted, go to RUN, set `seed_ready`=0 and clear `req_cnt`.
- **RUN.**
  - On `read_en`=1 with no rotation active: pop the FIFO into `coeff`, increment `req_cnt`, then rotate `shift_row` left by 1 (bit ROW_W-1 wraps into bit 0) for WORD_W consecutive cycles.
  - FIFO empty on a request: `coeff` becomes 0, `err[0]` is set, and rotation still runs.
  - `read_en` during an active rotation, or when `req_cnt`==N_REQ: set `err[1]`, do not pop, do not restart rotation.
  - `read_en` held high counts only once per rising edge of `read_en`.
  - `write_en`=1: capture `final_result` into the output buffer and go to DRAIN. This happens even if `req_cnt`<N_REQ (no error).
- **DRAIN.**
  - Present buffer word j (bits 32j+31:32j) on `res_data` with `res_valid`=1. Advance on valid && ready.
  - After word 95 is accepted: `res_valid`=0, clear `shift_row`, return to IDLE.
  - `read_en` in DRAIN sets `err[1]`.
- **Ignored inputs.** `write_en` outside RUN has no effect. `seed_valid` outside IDLE/LOAD has no effect.
- **Coefficient FIFO.** It accepts `cf_data` in every state. A simultaneous push and pop on a full FIFO is allowed: the pop frees the slot in the same cycle.
- **Clearing `err`.** Only reset clears it.

## Timing
- `read_en` sampled high at edge E: `coeff` is valid from E+1 and held until the next accepted request.
- Rotations occur at edges E+2 … E+33, exactly 32.
- A new request is accepted from edge E+33 onward.
- Seed load takes 96 handshake cycles minimum. It runs back-to-back when `seed_valid` is held high.
- `write_en` at edge W: first `res_valid` is visible at W+1. With `res_ready`=1 constantly, the last word is accepted at W+96 and IDLE is reached at W+96.
- `cf_ready` is combinational from FIFO occupancy. All other outputs are registered.

## Structure
- Shared package `toeplitz_pkg`:
  - `ROW_W`, `WORD_W`, `N_REQ`, `N_WORDS = ROW_W/WORD_W` (96).
  - State enum: IDLE, LOAD, RUN, DRAIN.
  - `err` bit indices.
- Sub-module `coeff_fifo`: synchronous FIFO, FIFO_D × WORD_W, push/pop/full/empty.
- Top level holds the FSM, seed and word counters, the rotation counter (0..32) and the output buffer.

## Test plan
- **Seed load.** Load words i = 0x1000_0000+i for i = 0…95 → `shift_row[31:0]`=0x1000_0000, `shift_row[3071:3040]`=0x1000_005F, state RUN.
- **Single request.** Seed = only bit 0 set, FIFO holds 0xA5A5_A5A5. Pulse `read_en` → `coeff`=0xA5A5_A5A5 at E+1; after 32 rotations only bit 32 is set.
- **Wrap-around.** Seed = only bit 3071 set. One request → after the first rotation bit 0 is set; after 32 rotations bit 31 is set.
- **Underflow and protocol error.**
  - Request with an empty FIFO → `coeff`=0, `err`=01.
  - Second pulse at E+10 → `err`=11; rotation count stays 32 total.
- **Result drain with backpressure.**
  - `final_result` word j = j. Pulse `write_en` → `res_data` sequence 0…95.
  - Toggle `res_ready` every cycle → no word lost or duplicated; IDLE after word 95.
- **Reset mid-operation.** Assert `rst_n`=0 during DRAIN word 40 → `res_valid`=0, `shift_row`=0, `busy`=0 immediately (async), `err`=0.
